// File: rtl/lr_shift_pkg.sv
// ============================================================================
// Module   : lr_shift_pkg
// Purpose  : Direction and state encodings shared by the word serializer and
//            the receiving left/right shift stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lr_shift_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lr_word_hold.sv
// ============================================================================
// Module   : lr_word_hold
// Purpose  : Single-entry data+direction skid register in front of the shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_word_hold
    import lr_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_dir,
    output logic             hold_full,
    output logic             in_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             r_full;

    // push only happens while empty and pop only while full, so they never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_dir  <= DIR_MSB_FIRST;
            r_full <= 1'b0;
        end else if (push) begin
            r_data <= in_data;
            r_dir  <= in_dir;
            r_full <= 1'b1;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    assign hold_data = r_data;
    assign hold_dir  = r_dir;
    assign hold_full = r_full;
    assign in_ready  = !r_full;

endmodule

`default_nettype wire

// File: rtl/lr_word_serializer.sv
// ============================================================================
// Module   : lr_word_serializer
// Purpose  : Parallel-to-serial shifter with per-word direction and framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_word_serializer
    import lr_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             so_en,
    output logic             so,
    output logic             so_valid,
    output logic             so_first,
    output logic             so_last
);

    localparam int                c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic               r_dir;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_so;
    logic               r_so_valid;
    logic               r_so_first;
    logic               r_so_last;

    logic [WIDTH-1:0]   w_hold_data;
    logic               w_hold_dir;
    logic               w_hold_full;
    logic               w_xfer;
    logic               w_frame_end;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_ld_data;
    logic               w_ld_dir;
    logic               w_ld_bit;
    logic               w_nxt_bit;

    assign w_xfer      = in_valid && in_ready;
    assign w_frame_end = (r_state == ST_SHIFT) && so_en && (r_cnt == c_last);
    // a word arriving exactly at the frame boundary bypasses the hold register
    assign w_push      = w_xfer && (r_state == ST_SHIFT) && !w_frame_end;
    assign w_pop       = w_frame_end && w_hold_full;

    assign w_ld_data = w_hold_full ? w_hold_data : in_data;
    assign w_ld_dir  = w_hold_full ? w_hold_dir  : in_dir;
    assign w_ld_bit  = (w_ld_dir == DIR_LSB_FIRST) ? w_ld_data[0] : w_ld_data[WIDTH-1];
    assign w_nxt_bit = (r_dir == DIR_LSB_FIRST) ? r_sreg[1] : r_sreg[WIDTH-2];

    lr_word_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .push      (w_push),
        .pop       (w_pop),
        .hold_data (w_hold_data),
        .hold_dir  (w_hold_dir),
        .hold_full (w_hold_full),
        .in_ready  (in_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sreg     <= '0;
            r_dir      <= DIR_MSB_FIRST;
            r_cnt      <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_so_first <= 1'b0;
            r_so_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_state    <= ST_SHIFT;
                        r_sreg     <= w_ld_data;
                        r_dir      <= w_ld_dir;
                        r_cnt      <= '0;
                        r_so       <= w_ld_bit;
                        r_so_valid <= 1'b1;
                        r_so_first <= 1'b1;
                        r_so_last  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (so_en) begin
                        if (r_cnt != c_last) begin
                            r_sreg     <= (r_dir == DIR_LSB_FIRST) ? (r_sreg >> 1) : (r_sreg << 1);
                            r_cnt      <= r_cnt + c_one;
                            r_so       <= w_nxt_bit;
                            r_so_first <= 1'b0;
                            r_so_last  <= ((r_cnt + c_one) == c_last);
                        end else if (w_hold_full || w_xfer) begin
                            r_sreg     <= w_ld_data;
                            r_dir      <= w_ld_dir;
                            r_cnt      <= '0;
                            r_so       <= w_ld_bit;
                            r_so_first <= 1'b1;
                            r_so_last  <= 1'b0;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_cnt      <= '0;
                            r_so       <= 1'b0;
                            r_so_valid <= 1'b0;
                            r_so_first <= 1'b0;
                            r_so_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign so       = r_so;
    assign so_valid = r_so_valid;
    assign so_first = r_so_first;
    assign so_last  = r_so_last;

endmodule

`default_nettype wire

// File: tb/tb_lr_word_serializer.sv
// ============================================================================
// Module   : tb_lr_word_serializer
// Purpose  : Scoreboard bench for lr_word_serializer with directed words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lr_word_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_dir;
    logic         in_valid;
    logic         in_ready;
    logic         so_en;
    logic         so;
    logic         so_valid;
    logic         so_first;
    logic         so_last;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_dis = 1'b0;
    logic prev_so  = 1'b0;

    always #5 clk = ~clk;

    lr_word_serializer #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .so_en    (so_en),
        .so       (so),
        .so_valid (so_valid),
        .so_first (so_first),
        .so_last  (so_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // A bit is consumed on each edge where so_en is high; compare it then.
    always @(negedge clk) begin
        if (!rst && so_valid) begin
            if (prev_dis)
                check("so_held_when_disabled", so, prev_so);
            if (so_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", so_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("so", so, mon_e.b);
                    check("so_first", so_first, mon_e.f);
                    check("so_last", so_last, mon_e.l);
                end
            end
        end
        prev_dis = !rst && so_valid && !so_en;
        prev_so  = so;
    end

    task automatic send(input logic [W-1:0] d, input logic dir);
        exp_t e;
        logic ok;
        for (int k = 0; k < W; k++) begin
            e.b = dir ? d[k] : d[W-1-k];
            e.f = (k == 0);
            e.l = (k == W - 1);
            exp_q.push_back(e);
        end
        in_data  = d;
        in_dir   = dir;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", ok, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || so_valid) && n < 300) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 300) check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        so_en    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_so", so, 1'b0);
        check("rst_so_valid", so_valid, 1'b0);
        check("rst_so_first", so_first, 1'b0);
        check("rst_so_last", so_last, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // MSB-first, one-cycle latency
        send(8'h2D, 1'b0);
        check("latency_valid", so_valid, 1'b1);
        check("latency_first", so_first, 1'b1);
        drain();
        check("idle_after_frame", so_valid, 1'b0);
        check("idle_ready", in_ready, 1'b1);

        // LSB-first
        send(8'h2D, 1'b1);
        drain();

        // back-to-back, mixed direction
        send(8'hF0, 1'b0);
        send(8'h0F, 1'b1);
        check("ready_low_hold", in_ready, 1'b0);
        n = 0;
        while (!in_ready && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check("ready_low_cycles", n, 7);
        drain();

        // so_en toggling, starting disabled
        send(8'h81, 1'b0);
        so_en = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (so_valid) n++;
            @(posedge clk); #1;
            so_en = ~so_en;
        end
        so_en = 1'b1;
        check("toggle_span", n, 16);
        drain();

        // reset mid-frame with a held word
        send(8'hAA, 1'b0);
        send(8'h55, 1'b1);
        n = 0;
        while (exp_q.size() > 12 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check("reach_bit4", exp_q.size() <= 12, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_so_valid", so_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_so", so, 1'b0);
        check("midrst_first", so_first, 1'b0);
        check("midrst_last", so_last, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        send(8'h01, 1'b1);
        drain();

        // in_valid during reset is ignored
        rst      = 1'b1;
        in_data  = 8'hFF;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("rstvalid_no_frame", so_valid, 1'b0);
        check("rstvalid_ready", in_ready, 1'b1);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
